// File: rtl/fifo_arb_pkg.sv
// Shared definitions for shared-FIFO merge arbiters: state encoding,
// end-of-packet bit location and the round-robin pointer increment.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // End-of-packet marker sits in the MSB of every beat.
  function automatic int unsigned eop_bit(input int unsigned data_width);
    return data_width - 1;
  endfunction

  // Modulo increment by explicit compare so non-power-of-2 counts never
  // produce an index >= num_in.
  function automatic int unsigned rr_next(input int unsigned ptr,
                                          input int unsigned num_in);
    return (ptr == num_in - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_rr_merge_arbiter_picker.sv
// Combinational round-robin picker: first asserted request scanning
// upward from ptr, wrapping modulo NUM_IN.
module rr_priority_picker #(
  parameter int NUM_IN    = 4,
  parameter int IDX_WIDTH = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0]    req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic                 valid,
  output logic [IDX_WIDTH-1:0] idx
);

  localparam logic [IDX_WIDTH:0] NUM_IN_W = (IDX_WIDTH+1)'(NUM_IN);

  logic [IDX_WIDTH:0] cand;

  // Scan ptr, ptr+1, ... ; ptr < NUM_IN so a single subtraction wraps.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      cand = {1'b0, ptr} + (IDX_WIDTH+1)'(k);
      if (cand >= NUM_IN_W) cand = cand - NUM_IN_W;
      if (!valid && req[cand[IDX_WIDTH-1:0]]) begin
        valid = 1'b1;
        idx   = cand[IDX_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_rr_merge_arbiter.sv
// Merges NUM_IN upstream FIFO read ports into one registered downstream
// write port with round-robin arbitration and optional packet lock.
module fifo_rr_merge_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int PKT_MODE   = 0,
  parameter int IDX_WIDTH  = $clog2(NUM_IN)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_IN-1:0]            in_empty_n,
  output logic [NUM_IN-1:0]            in_read,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_dout,
  input  logic                         out_full_n,
  output logic                         out_write,
  output logic [DATA_WIDTH-1:0]        out_din,
  output logic [IDX_WIDTH-1:0]         grant_idx,
  output logic                         locked
);

  localparam int unsigned EOP_BIT = eop_bit(DATA_WIDTH);

  arb_state_e             state_q, state_d;
  logic [IDX_WIDTH-1:0]   ptr_q, lock_idx_q, grant_q;
  logic                   run_q;
  logic                   pick_valid;
  logic [IDX_WIDTH-1:0]   pick_idx;
  logic [IDX_WIDTH-1:0]   sel_idx, ptr_adv;
  logic                   sel_valid, pop, sel_eop;
  logic [DATA_WIDTH-1:0]  sel_data;

  rr_priority_picker #(
    .NUM_IN   (NUM_IN),
    .IDX_WIDTH(IDX_WIDTH)
  ) u_picker (
    .req  (in_empty_n),
    .ptr  (ptr_q),
    .valid(pick_valid),
    .idx  (pick_idx)
  );

  // Select the serviced input (picker or locked owner) and form the pop.
  // run_q holds pops off until the first clock edge after reset release.
  always_comb begin
    sel_idx   = (state_q == LOCKED) ? lock_idx_q : pick_idx;
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (IDX_WIDTH'(i) == sel_idx) begin
        sel_valid = in_empty_n[i];
        sel_data  = in_dout[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    pop     = run_q & out_full_n & sel_valid;
    sel_eop = sel_data[EOP_BIT];
    ptr_adv = IDX_WIDTH'(rr_next(32'(sel_idx), NUM_IN));
    in_read = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      in_read[i] = pop && (IDX_WIDTH'(i) == sel_idx);
    end
  end

  // Packet-lock next state; only leaves ARB when packet mode is enabled.
  always_comb begin
    state_d = state_q;
    if (PKT_MODE != 0 && pop) begin
      case (state_q)
        ARB:     if (!sel_eop) state_d = LOCKED;
        LOCKED:  if (sel_eop)  state_d = ARB;
        default: state_d = ARB;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ARB;
    else          state_q <= state_d;
  end

  // Output register, pointer, grant and lock owner.
  // While locked sel_idx equals lock_idx, so the EOP advance uses ptr_adv too.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q      <= 1'b0;
      out_write  <= 1'b0;
      out_din    <= '0;
      ptr_q      <= '0;
      lock_idx_q <= '0;
      grant_q    <= '0;
    end else begin
      run_q     <= 1'b1;
      out_write <= pop;
      if (pop) begin
        out_din <= sel_data;
        grant_q <= sel_idx;
        if (state_q == ARB || sel_eop) ptr_q <= ptr_adv;
        if (state_q == ARB) lock_idx_q <= sel_idx;
      end
    end
  end

  assign grant_idx = grant_q;
  assign locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_fifo_rr_merge_arbiter.sv
// Directed scoreboard bench: one PKT_MODE=0 and one PKT_MODE=1 instance,
// each fed by bench-side source queues.
module tb_fifo_rr_merge_arbiter;

  logic        clk;
  logic        reset_n;
  logic        out_full_n;
  logic [3:0]  in_empty_n [2];
  logic [127:0] in_dout   [2];
  logic [3:0]  rd0, rd1;
  logic        ow0, ow1, lk0, lk1;
  logic [31:0] od0, od1;
  logic [1:0]  gi0, gi1;

  logic [31:0] srcq [2][4][$];
  logic [31:0] expq [2][$];
  int          pops [2][4];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          wr_cnt0 = 0;
  int          first0 = -1;
  int          last0 = -1;

  fifo_rr_merge_arbiter #(.NUM_IN(4), .DATA_WIDTH(32), .PKT_MODE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_empty_n(in_empty_n[0]), .in_read(rd0),
    .in_dout(in_dout[0]), .out_full_n(out_full_n), .out_write(ow0),
    .out_din(od0), .grant_idx(gi0), .locked(lk0));

  fifo_rr_merge_arbiter #(.NUM_IN(4), .DATA_WIDTH(32), .PKT_MODE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_empty_n(in_empty_n[1]), .in_read(rd1),
    .in_dout(in_dout[1]), .out_full_n(out_full_n), .out_write(ow1),
    .out_din(od1), .grant_idx(gi1), .locked(lk1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input bit ok,
                     input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input bit eop, input int src, input int n);
    return {eop, 7'h0, 8'(src), 16'(n)};
  endfunction

  task automatic refresh();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        in_empty_n[d][i] = (srcq[d][i].size() > 0);
        in_dout[d][i*32 +: 32] = (srcq[d][i].size() > 0) ? srcq[d][i][0] : 32'h0;
      end
    end
  endtask

  task automatic wait_drain(input int d, input int budget, input string tag);
    int c = 0;
    while (expq[d].size() != 0 && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk(tag, expq[d].size() === 0, expq[d].size(), 0);
  endtask

  always @(posedge clk) begin
    logic [3:0] r0, r1;
    r0 = rd0;
    r1 = rd1;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (r0[i] && srcq[0][i].size() > 0) begin void'(srcq[0][i].pop_front()); pops[0][i]++; end
      if (r1[i] && srcq[1][i].size() > 0) begin void'(srcq[1][i].pop_front()); pops[1][i]++; end
    end
    refresh();
  end

  always @(negedge clk) begin
    logic [31:0] e;
    cyc++;
    if (reset_n) begin
      if (ow0) begin
        wr_cnt0++;
        if (first0 < 0) first0 = cyc;
        last0 = cyc;
        chk("d0_exp_avail", expq[0].size() > 0, expq[0].size(), 1);
        if (expq[0].size() > 0) begin
          e = expq[0].pop_front();
          chk("d0_out_din", od0 === e, od0, e);
        end
      end
      if (ow1) begin
        chk("d1_exp_avail", expq[1].size() > 0, expq[1].size(), 1);
        if (expq[1].size() > 0) begin
          e = expq[1].pop_front();
          chk("d1_out_din", od1 === e, od1, e);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int ord [4];
    int p0, p2, snap, snap_c;
    ord = '{2, 3, 0, 1};
    for (int d = 0; d < 2; d++) for (int i = 0; i < 4; i++) pops[d][i] = 0;
    clk = 0; reset_n = 0; out_full_n = 1;
    refresh();
    repeat (2) @(negedge clk);

    for (int n = 0; n < 3; n++)
      for (int i = 0; i < 4; i++) begin
        srcq[0][i].push_back(mk(n == 1, i, n));
        expq[0].push_back(mk(n == 1, i, n));
      end
    refresh();
    #1;
    chk("rst_out_write0", ow0 === 1'b0, ow0, 0);
    chk("rst_out_din0", od0 === 32'h0, od0, 0);
    chk("rst_in_read0", rd0 === 4'h0, rd0, 0);
    chk("rst_grant0", gi0 === 2'd0, gi0, 0);
    chk("rst_locked0", lk0 === 1'b0, lk0, 0);
    chk("rst_out_write1", ow1 === 1'b0, ow1, 0);
    chk("rst_locked1", lk1 === 1'b0, lk1, 0);
    @(negedge clk);
    reset_n = 1;
    wait_drain(0, 40, "a_drain");
    chk("a_count", wr_cnt0 === 12, wr_cnt0, 12);
    chk("a_contiguous", (last0 - first0 + 1) === 12, last0 - first0 + 1, 12);
    chk("a_grant", gi0 === 2'd3, gi0, 3);

    @(negedge clk);
    srcq[0][1].push_back(mk(0, 1, 100));
    expq[0].push_back(mk(0, 1, 100));
    refresh();
    wait_drain(0, 10, "b_pre_drain");
    p0 = pops[0][0];
    p2 = pops[0][2];
    srcq[0][1].push_back(mk(0, 1, 101));
    srcq[0][1].push_back(mk(0, 1, 102));
    srcq[0][3].push_back(mk(0, 3, 101));
    srcq[0][3].push_back(mk(0, 3, 102));
    expq[0].push_back(mk(0, 3, 101));
    expq[0].push_back(mk(0, 1, 101));
    expq[0].push_back(mk(0, 3, 102));
    expq[0].push_back(mk(0, 1, 102));
    refresh();
    wait_drain(0, 20, "b_drain");
    chk("b_grant", gi0 === 2'd1, gi0, 1);
    chk("b_no_pop_in0", pops[0][0] === p0, pops[0][0], p0);
    chk("b_no_pop_in2", pops[0][2] === p2, pops[0][2], p2);

    @(negedge clk);
    snap_c = wr_cnt0;
    for (int n = 0; n < 4; n++)
      for (int i = 0; i < 4; i++) srcq[0][i].push_back(mk(0, i, 200 + n));
    for (int n = 0; n < 4; n++)
      for (int k = 0; k < 4; k++) expq[0].push_back(mk(0, ord[k], 200 + n));
    refresh();
    repeat (5) @(negedge clk);
    out_full_n = 0;
    @(posedge clk);
    #2;
    snap = wr_cnt0;
    chk("c_stall_read", rd0 === 4'h0, rd0, 0);
    repeat (4) begin
      @(posedge clk);
      #2;
      chk("c_stall_read", rd0 === 4'h0, rd0, 0);
    end
    @(negedge clk);
    out_full_n = 1;
    #1;
    chk("c_stall_writes_le1", (wr_cnt0 - snap) <= 1, wr_cnt0 - snap, 1);
    wait_drain(0, 60, "c_drain");
    chk("c_count", (wr_cnt0 - snap_c) === 16, wr_cnt0 - snap_c, 16);

    @(negedge clk);
    srcq[1][0].push_back(mk(0, 0, 1));
    srcq[1][0].push_back(mk(0, 0, 2));
    srcq[1][0].push_back(mk(1, 0, 3));
    srcq[1][1].push_back(mk(1, 1, 1));
    srcq[1][1].push_back(mk(1, 1, 2));
    expq[1].push_back(mk(0, 0, 1));
    expq[1].push_back(mk(0, 0, 2));
    expq[1].push_back(mk(1, 0, 3));
    expq[1].push_back(mk(1, 1, 1));
    expq[1].push_back(mk(1, 1, 2));
    refresh();
    #1;
    chk("d_first_read", rd1 === 4'b0001, rd1, 4'b0001);
    chk("d_first_locked", lk1 === 1'b0, lk1, 0);
    @(negedge clk); #1;
    chk("d_beat_b_read", rd1 === 4'b0001, rd1, 4'b0001);
    chk("d_beat_b_locked", lk1 === 1'b1, lk1, 1);
    @(negedge clk); #1;
    chk("d_beat_c_read", rd1 === 4'b0001, rd1, 4'b0001);
    chk("d_beat_c_locked", lk1 === 1'b1, lk1, 1);
    @(negedge clk); #1;
    chk("d_after_eop_read", rd1 === 4'b0010, rd1, 4'b0010);
    chk("d_after_eop_locked", lk1 === 1'b0, lk1, 0);
    wait_drain(1, 20, "d_drain");

    @(negedge clk);
    srcq[1][2].push_back(mk(0, 2, 1));
    srcq[1][0].push_back(mk(1, 0, 9));
    srcq[1][1].push_back(mk(1, 1, 9));
    expq[1].push_back(mk(0, 2, 1));
    expq[1].push_back(mk(0, 2, 2));
    expq[1].push_back(mk(1, 2, 3));
    expq[1].push_back(mk(1, 0, 9));
    expq[1].push_back(mk(1, 1, 9));
    refresh();
    #1;
    chk("e_first_read", rd1 === 4'b0100, rd1, 4'b0100);
    repeat (4) begin
      @(negedge clk); #1;
      chk("e_stall_read", rd1 === 4'h0, rd1, 0);
      chk("e_stall_locked", lk1 === 1'b1, lk1, 1);
    end
    srcq[1][2].push_back(mk(0, 2, 2));
    srcq[1][2].push_back(mk(1, 2, 3));
    refresh();
    #1;
    chk("e_refill_read", rd1 === 4'b0100, rd1, 4'b0100);
    wait_drain(1, 20, "e_drain");
    chk("e_grant", gi1 === 2'd1, gi1, 1);

    @(negedge clk);
    srcq[1][1].push_back(mk(0, 1, 50));
    srcq[1][1].push_back(mk(0, 1, 51));
    srcq[1][1].push_back(mk(1, 1, 52));
    expq[1].push_back(mk(0, 1, 50));
    refresh();
    #1;
    chk("f_first_read", rd1 === 4'b0010, rd1, 4'b0010);
    @(negedge clk); #1;
    chk("f_locked_mid", lk1 === 1'b1, lk1, 1);
    @(posedge clk);
    #3;
    reset_n = 0;
    #1;
    chk("f_rst_out_write", ow1 === 1'b0, ow1, 0);
    chk("f_rst_in_read", rd1 === 4'h0, rd1, 0);
    chk("f_rst_locked", lk1 === 1'b0, lk1, 0);
    chk("f_rst_grant", gi1 === 2'd0, gi1, 0);
    for (int i = 0; i < 4; i++) srcq[1][i].delete();
    expq[1].delete();
    refresh();
    @(negedge clk);
    reset_n = 1;
    srcq[1][2].push_back(mk(1, 2, 60));
    srcq[1][0].push_back(mk(1, 0, 60));
    expq[1].push_back(mk(1, 0, 60));
    expq[1].push_back(mk(1, 2, 60));
    refresh();
    wait_drain(1, 20, "f_drain");
    chk("f_grant", gi1 === 2'd2, gi1, 2);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
